// File: rtl/hazard_pkg.sv
// Shared constants and the in-flight scoreboard entry type for the hazard unit.
package hazard_pkg;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Default architectural zero register (XZR); reads of it never depend on anyone.
    localparam int ZERO_REG_DEFAULT = 31;

    // Widest register index a scoreboard entry can hold; narrower indices are zero-extended.
    localparam int MAX_REG_ADDR_W = 8;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] rd;
        logic                      regwrite;
        logic                      memread;
    } sb_entry_t;

endpackage

// File: rtl/inflight_scoreboard.sv
// Shift register of post-decode instructions: entry k is the instruction in stage k.
module inflight_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  sb_entry_t              load_entry,
    output sb_entry_t [DEPTH:1]    entries
);

    sb_entry_t [DEPTH:1] entry_reg;
    sb_entry_t           entry_next [1:DEPTH];

    // Entry 1 takes the decoded instruction (or a bubble); every older entry takes its younger neighbour.
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_shift
        if (gi == 1) begin : g_head
            assign entry_next[gi] = load_entry;
        end else begin : g_tail
            assign entry_next[gi] = entry_reg[gi-1];
        end
    end

    // Advance the whole pipeline image every edge; the oldest entry simply falls off.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry_reg <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                entry_reg[k] <= entry_next[k];
            end
        end
    end

    assign entries = entry_reg;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, branch flush and operand forwarding control for the pipelined datapath.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 3,
    parameter int ZERO_REG   = ZERO_REG_DEFAULT,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush_ifid,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel
);

    sb_entry_t [DEPTH:1] entries;
    sb_entry_t           load_entry;
    logic                issue;

    logic [DEPTH:1]      match_a;
    logic [DEPTH:1]      match_b;
    logic                src_a_live;
    logic                src_b_live;

    logic [SEL_W-1:0]    sel_a_next;
    logic [SEL_W-1:0]    sel_b_next;
    logic                stall_a;
    logic                stall_b;

    logic [SEL_W-1:0]    fwd_a_sel_reg;
    logic [SEL_W-1:0]    fwd_b_sel_reg;

    // A source only creates a dependency if a real instruction reads it and it is not XZR.
    assign src_a_live = id_valid && id_rs1_used && (id_rs1 != REG_ADDR_W'(ZERO_REG));
    assign src_b_live = id_valid && id_rs2_used && (id_rs2 != REG_ADDR_W'(ZERO_REG));

    // Producer match per in-flight entry for each ID source.
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
        assign match_a[gi] = src_a_live && entries[gi].valid && entries[gi].regwrite
                             && (entries[gi].rd == MAX_REG_ADDR_W'(id_rs1));
        assign match_b[gi] = src_b_live && entries[gi].valid && entries[gi].regwrite
                             && (entries[gi].rd == MAX_REG_ADDR_W'(id_rs2));
    end

    // Youngest producer wins: scan oldest to youngest so the lowest k is written last.
    // A producer in the last tracked stage has already written the register file by use time.
    always_comb begin
        sel_a_next = SEL_W'(FWD_RF);
        sel_b_next = SEL_W'(FWD_RF);
        stall_a    = 1'b0;
        stall_b    = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_a[k]) begin
                sel_a_next = (k < DEPTH) ? SEL_W'(k + 1) : SEL_W'(FWD_RF);
                stall_a    = entries[k].memread && (k + 1 < LOAD_STAGE);
            end
            if (match_b[k]) begin
                sel_b_next = (k < DEPTH) ? SEL_W'(k + 1) : SEL_W'(FWD_RF);
                stall_b    = entries[k].memread && (k + 1 < LOAD_STAGE);
            end
        end
    end

    // A taken branch kills the ID instruction, so it cannot also be held.
    assign stall      = (stall_a || stall_b) && !ex_flush;
    assign bubble     = stall || ex_flush;
    assign flush_ifid = ex_flush;
    assign issue      = id_valid && !stall && !ex_flush;

    // Entry 1 receives the ID instruction only when it actually advances into EX.
    always_comb begin
        load_entry          = '0;
        load_entry.valid    = issue;
        load_entry.rd       = MAX_REG_ADDR_W'(id_rd);
        load_entry.regwrite = issue && id_regwrite;
        load_entry.memread  = issue && id_memread;
    end

    inflight_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .load_entry (load_entry),
        .entries    (entries)
    );

    // Forwarding selects travel with the instruction into EX; bubbles carry register-file selects.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_a_sel_reg <= SEL_W'(FWD_RF);
            fwd_b_sel_reg <= SEL_W'(FWD_RF);
        end else if (issue) begin
            fwd_a_sel_reg <= sel_a_next;
            fwd_b_sel_reg <= sel_b_next;
        end else begin
            fwd_a_sel_reg <= SEL_W'(FWD_RF);
            fwd_b_sel_reg <= SEL_W'(FWD_RF);
        end
    end

    assign fwd_a_sel = fwd_a_sel_reg;
    assign fwd_b_sel = fwd_b_sel_reg;

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard and forwarding controller for the pipelined LEGv8 datapath. It tracks destination registers in flight after decode and generates the following:
- a load-use stall that can last several cycles;
- the bubble into ID/EX;
- the IF/ID flush on a taken branch;
- registered forwarding selects for both ALU operands.

It sits beside the ID stage. It replaces the current hazard-free pipeline behaviour and generalises to any post-decode depth and load latency.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); minimum 2
- LOAD_STAGE, 3, first stage index at which load data is forwardable; 2..DEPTH
- ZERO_REG, 31, register index that never creates a dependency (XZR)
- SEL_W, $clog2(DEPTH+1), forwarding-select width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source indices from IF/ID
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_ADDR_W  destination index
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- ex_flush  in  1  taken branch resolved in EX this cycle
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  load NOP controls into ID/EX this cycle
- flush_ifid  out  1  clear IF/ID at this edge
- fwd_a_sel, fwd_b_sel  out  SEL_W  operand source for instruction now in EX; 0 = register file, k = result from stage k

## Operation
- Scoreboard: DEPTH entries {valid, rd, regwrite, memread}; entry k describes the instruction in stage k.
- Each edge, entries shift k→k+1; entry DEPTH retires.
- Entry 1 loads the ID instruction if id_valid & !stall & !ex_flush; otherwise it loads a bubble (valid=0).
- Producer match for source s: entry valid, regwrite=1, rd==s, s≠ZERO_REG, and source used.
- At use time, the producer in entry k sits at stage k+1.
- Forward select: the youngest matching entry k with k+1 ≤ DEPTH gives sel = k+1. With no match, sel=0.
- A match only in entry DEPTH gives sel=0. The register file is write-before-read, and this is a system requirement.
- Load-use stall: stall=1 when any used source matches an entry k with memread=1 and k+1 < LOAD_STAGE.
  - The youngest match decides. If a younger non-load matches first, there is no stall.
  - Re-evaluated every cycle.
  - Stall length is LOAD_STAGE-1-k cycles.
- bubble = stall | ex_flush.
- flush_ifid = ex_flush.
- ex_flush overrides stall: stall=0 whenever ex_flush=1.
- The EX (branch) entry itself stays valid.
- fwd_*_sel register the values computed in ID when entry 1 loads a valid instruction. They clear to 0 when entry 1 loads a bubble.

## Timing
- stall, bubble, flush_ifid: combinational from scoreboard state and ID inputs, same cycle.
- fwd_*_sel: registered, valid the cycle the instruction is in EX (1-cycle latency from ID).
- Reset (synchronous): all entries invalid; fwd_a_sel=fwd_b_sel=0.
- After reset, stall=0 and flush_ifid follows ex_flush.
- Reset mid-stall drops the stall on the next cycle; the held instruction is reissued by the fetch logic.
- Simultaneous ex_flush and load-use: flush wins, no stall, the ID instruction is killed.
- id_valid=0: no stall, no forwarding, bubble enters entry 1.
- Same rd in several entries: the youngest (lowest k) is the source.

## Structure
- Package hazard_pkg:
  - FWD_RF=0 constant
  - ZERO_REG default
  - a scoreboard entry typedef {valid, rd, regwrite, memread}
- Sub-module inflight_scoreboard: shift register of DEPTH entries with load/bubble input. The match and priority logic stays in the top module.

## Test plan
- Default params. ADD X1 in EX; ID ADD X2,X1,X3 → stall=0, next cycle fwd_a_sel=2.
- Default params. LDUR X1 in EX; ID uses X1 → stall=1 and bubble=1 for exactly 1 cycle, then fwd_a_sel=3.
- DEPTH=4, LOAD_STAGE=4. LDUR X5 just entered EX; dependent in ID → 2 stall cycles, then fwd_b_sel=4.
- Source X31 while producer writes X31 → stall=0, sel=0.
- X1 written in both MEM and EX → fwd selects the EX producer (sel=2).
- ex_flush=1 during a load-use condition → stall=0, bubble=1, flush_ifid=1.
- Reset asserted mid-stall → next cycle stall=0, fwd_*_sel=0.
